// File: rtl/rom_burst_reader.sv
// Burst address sequencer for a 16x4 synchronous ROM: issues wrapping reads under
// a credit limit, buffers returned words in a 4-deep FIFO and streams them out.
module rom_burst_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] base_addr,
  input  logic [4:0] count,
  output logic       rom_en,
  output logic [3:0] rom_address,
  input  logic [3:0] rom_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_data,
  output logic [3:0] out_addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] checksum
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t     state;
  logic [4:0] remaining;
  logic       rd_vld;
  logic [3:0] rd_addr;
  logic [3:0] fifo_data [4];
  logic [3:0] fifo_addr [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] occ, occ_next;
  logic [3:0] credit_sum;
  logic       push, pop, credit;

  // rd_vld marks the cycle in which ROM data for the previous rom_en is on rom_data.
  assign push      = rd_vld;
  assign out_valid = (occ != 3'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_data[rd_ptr];
  assign out_addr  = fifo_addr[rd_ptr];

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 3'd1;
      2'b01:   occ_next = occ - 3'd1;
      default: occ_next = occ;
    endcase
  end

  // A new read is allowed only if every word already in flight plus this one fits.
  assign credit_sum = {1'b0, occ_next} + {3'b000, rom_en} + 4'd1;
  assign credit     = (credit_sum <= 4'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= 5'd0;
      rom_en      <= 1'b0;
      rom_address <= 4'd0;
      rd_vld      <= 1'b0;
      rd_addr     <= 4'd0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      occ         <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      checksum    <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_data[i] <= 4'd0;
        fifo_addr[i] <= 4'd0;
      end
    end else begin
      done    <= 1'b0;
      rom_en  <= 1'b0;
      rd_vld  <= rom_en;
      rd_addr <= rom_address;
      occ     <= occ_next;
      if (push) begin
        fifo_data[wr_ptr] <= rom_data;
        fifo_addr[wr_ptr] <= rd_addr;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 2'd1;
        checksum <= checksum + {4'd0, out_data};
      end
      case (state)
        IDLE: if (start) begin
          checksum <= 8'd0;
          busy     <= 1'b1;
          if (count == 5'd0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            // First read goes out on the accepting edge to hit 2-cycle latency.
            rom_en      <= 1'b1;
            rom_address <= base_addr;
            remaining   <= count - 5'd1;
            state       <= (count == 5'd1) ? DRAIN : READ;
          end
        end
        READ: if (credit) begin
          rom_en      <= 1'b1;
          rom_address <= rom_address + 4'd1;
          remaining   <= remaining - 5'd1;
          if (remaining == 5'd1) state <= DRAIN;
        end
        DRAIN: if (!rom_en && occ_next == 3'd0) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && occ == 3'd4 && !pop));

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader with a behavioural ROM holding mem[a] = ~a.
module tb_rom_burst_reader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base_addr = 4'd0;
  logic [4:0] count = 5'd0;
  logic       rom_en;
  logic [3:0] rom_address;
  logic [3:0] rom_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [3:0] out_addr;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;

  rom_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .rom_en(rom_en), .rom_address(rom_address), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [3:0] rom_q = 4'd0;
  always @(posedge clk) if (rom_en) rom_q <= ~rom_address;
  assign rom_data = rom_q;

  // Monitor: all counters reflect pre-edge DUT values sampled at each rising edge.
  int cyc = 0, s_cyc = 0, done_cyc = 0, done_cnt = 0, busy_cnt = 0, en_cnt = 0;
  logic [3:0] gd[$];
  logic [3:0] ga[$];
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (start && !busy) s_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (rom_en) en_cnt++;
      if (out_valid && out_ready) begin
        gd.push_back(out_data);
        ga.push_back(out_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [3:0] b, input logic [4:0] c);
    @(negedge clk);
    start = 1'b1; base_addr = b; count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int w = 0;
    while (done_cnt == d0 && w < 80) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_timeout"}, 32'(w < 80), 32'd1);
  endtask

  task automatic full_burst(input string tag);
    int d0, b0, e0, q0;
    d0 = done_cnt; b0 = busy_cnt; e0 = en_cnt; q0 = gd.size();
    out_ready = 1'b1;
    go(4'd0, 5'd16);
    chk({tag, "_en0"}, 32'(rom_en), 32'd1);
    chk({tag, "_addr0"}, 32'(rom_address), 32'd0);
    chk({tag, "_busy0"}, 32'(busy), 32'd1);
    wait_done(tag, d0);
    @(negedge clk);
    chk({tag, "_nwords"}, 32'(gd.size() - q0), 32'd16);
    for (int i = 0; i < 16 && q0 + i < gd.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), 32'(gd[q0+i]), 32'(15 - i));
      chk($sformatf("%s_oaddr%0d", tag, i), 32'(ga[q0+i]), 32'(i));
    end
    chk({tag, "_checksum"}, 32'(checksum), 32'd120);
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_done_lat"}, 32'(done_cyc - s_cyc), 32'd19);
    chk({tag, "_busy_cyc"}, 32'(busy_cnt - b0), 32'd19);
    chk({tag, "_en_cnt"}, 32'(en_cnt - e0), 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, q0;
    logic [3:0] wa [4];
    logic [3:0] wd [4];

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_address", 32'(rom_address), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b0;

    full_burst("full");

    // Wrap-around with an ignored mid-burst start
    wa[0] = 4'd14; wa[1] = 4'd15; wa[2] = 4'd0; wa[3] = 4'd1;
    wd[0] = 4'h1;  wd[1] = 4'h0;  wd[2] = 4'hF; wd[3] = 4'hE;
    d0 = done_cnt; e0 = en_cnt; q0 = gd.size();
    out_ready = 1'b1;
    go(4'd14, 5'd4);
    chk("wrap_addr0", 32'(rom_address), 32'd14);
    @(negedge clk);
    start = 1'b1; base_addr = 4'd3; count = 5'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("wrap", d0);
    @(negedge clk);
    chk("wrap_nwords", 32'(gd.size() - q0), 32'd4);
    for (int i = 0; i < 4 && q0 + i < gd.size(); i++) begin
      chk($sformatf("wrap_oaddr%0d", i), 32'(ga[q0+i]), 32'(wa[i]));
      chk($sformatf("wrap_data%0d", i), 32'(gd[q0+i]), 32'(wd[i]));
    end
    chk("wrap_checksum", 32'(checksum), 32'd30);
    chk("wrap_en_cnt", 32'(en_cnt - e0), 32'd4);
    chk("wrap_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("wrap_idle", 32'(busy), 32'd0);

    // Backpressure
    d0 = done_cnt; e0 = en_cnt; q0 = gd.size();
    out_ready = 1'b0;
    go(4'd0, 5'd8);
    repeat (3) @(negedge clk);
    chk("bp_data_early", 32'(out_data), 32'hF);
    repeat (6) @(negedge clk);
    chk("bp_en_cnt", 32'(en_cnt - e0), 32'd4);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data_hold", 32'(out_data), 32'hF);
    chk("bp_addr_hold", 32'(out_addr), 32'd0);
    chk("bp_rom_en_low", 32'(rom_en), 32'd0);
    out_ready = 1'b1;
    wait_done("bp", d0);
    @(negedge clk);
    chk("bp_nwords", 32'(gd.size() - q0), 32'd8);
    for (int i = 0; i < 8 && q0 + i < gd.size(); i++) begin
      chk($sformatf("bp_data%0d", i), 32'(gd[q0+i]), 32'(15 - i));
      chk($sformatf("bp_oaddr%0d", i), 32'(ga[q0+i]), 32'(i));
    end
    chk("bp_checksum", 32'(checksum), 32'd92);
    chk("bp_en_total", 32'(en_cnt - e0), 32'd8);

    // Zero count
    d0 = done_cnt; e0 = en_cnt;
    go(4'd5, 5'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_rom_en", 32'(rom_en), 32'd0);
    @(negedge clk);
    chk("zero_done_lat", 32'(done_cyc - s_cyc), 32'd1);
    chk("zero_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("zero_en_cnt", 32'(en_cnt - e0), 32'd0);
    chk("zero_checksum", 32'(checksum), 32'd0);
    chk("zero_idle", 32'(busy), 32'd0);

    // Reset mid-burst
    d0 = done_cnt;
    out_ready = 1'b1;
    go(4'd0, 5'd16);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rom_en", 32'(rom_en), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_checksum", 32'(checksum), 32'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mid_rst_stay_idle", 32'(busy), 32'd0);

    full_burst("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
